fc16_stream_driver: RTL and testbench

- Producer/consumer front-end for one FC_16 dot-product unit: packs a serial FP32 activation stream into 16-lane vectors, drives the unit's valid_in and 5-bit valid-pipeline enables, and returns each dot-product result with a valid/last strobe.
- Sits between the activation buffer/DMA stream and an FC_16 instance in the VGG16 classifier datapath.
- Handles frame boundaries by zero-padding partial vectors and draining the pipeline before accepting the next frame.

---
 rtl/fc16_stream_driver.sv | 163 ++++++++++++++++
 tb/tb_fc16_stream_driver.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc16_stream_driver.sv
// fc16_stream_driver
//   Front-end for one FC_16 dot-product unit. Serial FP32 activation words
//   are packed into NUM_LANES-wide vectors. Each vector is issued to the FC
//   unit with a one-cycle valid_in strobe, and the unit's valid-pipeline
//   enables are driven from a shift chain. The FC result is returned with a
//   valid/last strobe. A partial final vector is zero-padded. Once a frame's
//   last word is taken, the pipeline drains before the next frame is accepted.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   s_data/s_valid/
//   s_last/s_ready     activation stream in (valid/ready handshake)
//   fc_data            packed vector to FC unit, lane n at [DW*(n+1)-1:DW*n]
//   fc_valid_in        one-cycle vector strobe to FC unit
//   fc_valid_pipeline  stage enables to FC unit
//   fc_o_data          registered result from FC unit
//   res_data/res_valid/
//   res_last           result out (no backpressure)
//   vec_count          vectors issued in the current frame (saturating)
//   busy               high while draining a frame
module fc16_stream_driver #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_LANES   = 16,
    parameter int PIPE_STAGES = 5,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    output logic [DATA_WIDTH*NUM_LANES-1:0] fc_data,
    output logic                            fc_valid_in,
    output logic [PIPE_STAGES-1:0]          fc_valid_pipeline,
    input  logic [DATA_WIDTH-1:0]           fc_o_data,
    output logic [DATA_WIDTH-1:0]           res_data,
    output logic                            res_valid,
    output logic                            res_last,
    output logic [CNT_WIDTH-1:0]            vec_count,
    output logic                            busy
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]                      state_q, state_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    logic [DATA_WIDTH*NUM_LANES-1:0] buf_q, buf_d;
    logic [DATA_WIDTH*NUM_LANES-1:0] fc_data_q, fc_data_d;
    logic                            fc_valid_in_q, fc_valid_in_d;
    logic                            issue_last_q, issue_last_d;
    logic [PIPE_STAGES-1:0]          vp_q, vp_d;
    logic [PIPE_STAGES-1:0]          lastp_q, lastp_d;
    logic                            res_valid_q, res_valid_d;
    logic                            res_last_q, res_last_d;
    logic [CNT_WIDTH-1:0]            vec_count_q, vec_count_d;

    logic                            accept;
    logic                            issue;
    logic [DATA_WIDTH*NUM_LANES-1:0] merged;

    assign s_ready = (state_q == ST_FILL);
    assign accept  = s_valid && s_ready;
    assign issue   = accept && (s_last || (idx_q == LAST_IDX));

    // Collect buffer with the incoming word placed at idx; lanes above idx
    // are forced to +0.0 so a partial vector contributes nothing.
    always_comb begin
        merged = '0;
        for (int unsigned n = 0; n < NUM_LANES; n++) begin
            if (IDX_W'(n) < idx_q)
                merged[n*DATA_WIDTH +: DATA_WIDTH] = buf_q[n*DATA_WIDTH +: DATA_WIDTH];
            else if (IDX_W'(n) == idx_q)
                merged[n*DATA_WIDTH +: DATA_WIDTH] = s_data;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        buf_d         = buf_q;
        fc_data_d     = fc_data_q;
        fc_valid_in_d = 1'b0;
        issue_last_d  = 1'b0;
        vec_count_d   = vec_count_q;

        if (accept) begin
            if (issue) begin
                fc_data_d     = merged;
                fc_valid_in_d = 1'b1;
                issue_last_d  = s_last;
                idx_d         = '0;
                buf_d         = '0;
                if (vec_count_q != '1)
                    vec_count_d = vec_count_q + CNT_WIDTH'(1);
            end else begin
                buf_d = merged;
                idx_d = idx_q + IDX_W'(1);
            end
        end

        vp_d        = {vp_q[PIPE_STAGES-2:0], fc_valid_in_q};
        lastp_d     = {lastp_q[PIPE_STAGES-2:0], issue_last_q};
        res_valid_d = vp_q[PIPE_STAGES-1];
        res_last_d  = vp_q[PIPE_STAGES-1] && lastp_q[PIPE_STAGES-1];

        case (state_q)
            ST_FILL: begin
                if (accept && s_last)
                    state_d = ST_DRAIN;
            end
            default: begin
                // The frame's final result leaves this cycle; reopen intake.
                if (res_valid_q && res_last_q) begin
                    state_d     = ST_FILL;
                    vec_count_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_FILL;
            idx_q         <= '0;
            buf_q         <= '0;
            fc_data_q     <= '0;
            fc_valid_in_q <= 1'b0;
            issue_last_q  <= 1'b0;
            vp_q          <= '0;
            lastp_q       <= '0;
            res_valid_q   <= 1'b0;
            res_last_q    <= 1'b0;
            vec_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            buf_q         <= buf_d;
            fc_data_q     <= fc_data_d;
            fc_valid_in_q <= fc_valid_in_d;
            issue_last_q  <= issue_last_d;
            vp_q          <= vp_d;
            lastp_q       <= lastp_d;
            res_valid_q   <= res_valid_d;
            res_last_q    <= res_last_d;
            vec_count_q   <= vec_count_d;
        end
    end

    assign fc_data           = fc_data_q;
    assign fc_valid_in       = fc_valid_in_q;
    assign fc_valid_pipeline = vp_q;
    assign res_data          = fc_o_data;
    assign res_valid         = res_valid_q;
    assign res_last          = res_last_q;
    assign vec_count         = vec_count_q;
    assign busy              = (state_q == ST_DRAIN);

endmodule

// File: tb/tb_fc16_stream_driver.sv
// Testbench for fc16_stream_driver. A stand-in FC unit returns a hash of
// each issued vector at the result cycle. The expected vectors, counts,
// results and timing are built from the driven words and queued at
// acceptance; a negedge monitor pops and compares them.
module tb_fc16_stream_driver;

    localparam int DW = 32;
    localparam int NL = 16;
    localparam int PS = 5;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [DW-1:0]    s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_last = 1'b0;
    logic             s_ready;
    logic [DW*NL-1:0] fc_data;
    logic             fc_valid_in;
    logic [PS-1:0]    fc_valid_pipeline;
    logic [DW-1:0]    fc_o_data = '0;
    logic [DW-1:0]    res_data;
    logic             res_valid;
    logic             res_last;
    logic [CW-1:0]    vec_count;
    logic             busy;

    fc16_stream_driver #(.DATA_WIDTH(DW), .NUM_LANES(NL), .PIPE_STAGES(PS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .fc_data(fc_data), .fc_valid_in(fc_valid_in),
        .fc_valid_pipeline(fc_valid_pipeline), .fc_o_data(fc_o_data),
        .res_data(res_data), .res_valid(res_valid), .res_last(res_last),
        .vec_count(vec_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW*NL-1:0] vec;
        logic [CW-1:0]    cnt;
        time              t;
    } vec_exp_t;

    typedef struct {
        logic [DW-1:0] res;
        logic          last;
        time           t;
    } res_exp_t;

    vec_exp_t      vec_q[$];
    res_exp_t      res_q[$];
    logic [DW-1:0] fc_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] mbuf [NL];
    int            midx = 0;
    logic [CW-1:0] mcnt = '0;

    function automatic logic [DW-1:0] hash_vec(input logic [DW*NL-1:0] v);
        logic [DW-1:0] s;
        s = 32'h1234_5678;
        for (int n = 0; n < NL; n++)
            s = {s[DW-2:0], s[DW-1]} ^ (v[n*DW +: DW] + DW'(n));
        return s;
    endfunction

    // Stand-in FC unit: registered result appears with res_valid.
    always @(posedge clk) begin
        if (fc_valid_pipeline[PS-1] && fc_q.size() > 0)
            fc_o_data <= fc_q.pop_front();
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst) begin
            if (fc_valid_in) begin
                vec_exp_t e;
                fc_q.push_back(hash_vec(fc_data));
                n_checks++;
                if (vec_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_issue: fc_valid_in=1 at %0t, none expected", $time);
                end else begin
                    e = vec_q.pop_front();
                    if (fc_data !== e.vec) begin
                        n_fail++;
                        $display("FAIL fc_data: got %h want %h", fc_data, e.vec);
                    end
                    n_checks++;
                    if (vec_count !== e.cnt) begin
                        n_fail++;
                        $display("FAIL vec_count_at_issue: got %0d want %0d", vec_count, e.cnt);
                    end
                    n_checks++;
                    if ($time != e.t + 5) begin
                        n_fail++;
                        $display("FAIL issue_latency: got t=%0t want t=%0t", $time, e.t + 5);
                    end
                end
            end
            if (res_valid) begin
                res_exp_t r;
                n_checks++;
                if (res_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: res_valid=1 at %0t, none expected", $time);
                end else begin
                    r = res_q.pop_front();
                    if (res_data !== r.res || res_last !== r.last) begin
                        n_fail++;
                        $display("FAIL result: got data=%h last=%b want data=%h last=%b",
                                 res_data, res_last, r.res, r.last);
                    end
                    n_checks++;
                    if ($time != r.t + 65) begin
                        n_fail++;
                        $display("FAIL result_latency: got t=%0t want t=%0t", $time, r.t + 65);
                    end
                end
            end
        end
    end

    // Entered and left at a negedge. Waits (bounded) for s_ready, then
    // updates the reference model at the accepting edge.
    task automatic send_word(input logic [DW-1:0] d, input logic l, output int waited);
        logic [DW*NL-1:0] v;
        waited  = 0;
        s_data  = d;
        s_last  = l;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: s_ready=%b after %0d cycles, want 1", s_ready, waited);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            mbuf[midx] = d;
            midx++;
            if (l || midx == NL) begin
                v = '0;
                for (int n = 0; n < midx; n++)
                    v[n*DW +: DW] = mbuf[n];
                if (mcnt != '1)
                    mcnt++;
                vec_q.push_back('{vec: v, cnt: mcnt, t: $time});
                res_q.push_back('{res: hash_vec(v), last: l, t: $time});
                midx = 0;
                if (l)
                    mcnt = '0;
            end
            @(negedge clk);
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((vec_q.size() != 0 || res_q.size() != 0 || s_ready !== 1'b1) && w < 200) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 200) begin
            n_fail++;
            $display("FAIL drain_timeout: pending vec=%0d res=%0d s_ready=%b, want 0/0/1",
                     vec_q.size(), res_q.size(), s_ready);
        end
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (2) @(negedge clk);
        vec_q.delete();
        res_q.delete();
        fc_q.delete();
        midx = 0;
        mcnt = '0;
        rst  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({fc_valid_in, fc_valid_pipeline, res_valid, res_last, busy} !== '0 || fc_data !== '0
            || vec_count !== '0 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: vin=%b vp=%b rv=%b rl=%b busy=%b cnt=%0d rdy=%b fc_data_nz=%b, want all 0 and rdy=1",
                     fc_valid_in, fc_valid_pipeline, res_valid, res_last, busy, vec_count, s_ready, |fc_data);
        end
    endtask

    task automatic test_single_frame();
        int w;
        for (int i = 0; i < NL; i++)
            send_word(32'h3F80_0000, i == NL - 1, w);
        // Now at the negedge of cycle T+1.
        for (int k = 1; k <= 8; k++) begin
            logic [PS-1:0] exp_vp;
            exp_vp = (k >= 2 && k <= 6) ? PS'(1 << (k - 2)) : '0;
            n_checks++;
            if (fc_valid_pipeline !== exp_vp) begin
                n_fail++;
                $display("FAIL pipeline_T+%0d: got %b want %b", k, fc_valid_pipeline, exp_vp);
            end
            n_checks++;
            if (s_ready !== (k == 8) || busy !== (k != 8)) begin
                n_fail++;
                $display("FAIL ready_busy_T+%0d: got rdy=%b busy=%b want rdy=%b busy=%b",
                         k, s_ready, busy, k == 8, k != 8);
            end
            n_checks++;
            if (vec_count !== ((k <= 7) ? CW'(1) : CW'(0))) begin
                n_fail++;
                $display("FAIL vec_count_T+%0d: got %0d want %0d", k, vec_count, (k <= 7) ? 1 : 0);
            end
            n_checks++;
            if ({res_valid, res_last} !== ((k == 7) ? 2'b11 : 2'b00)) begin
                n_fail++;
                $display("FAIL res_strobe_T+%0d: got %b%b want %b", k, res_valid, res_last, k == 7);
            end
            @(negedge clk);
        end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 3 * NL; i++) begin
            send_word(32'h4100_0000 + DW'(i), i == 3 * NL - 1, w);
            n_checks++;
            if (w != 0) begin
                n_fail++;
                $display("FAIL b2b_ready word %0d: waited %0d cycles, want 0", i, w);
            end
        end
        wait_drain();
    endtask

    task automatic test_partial();
        int w;
        for (int i = 0; i < 5; i++)
            send_word(32'h4000_0000, i == 4, w);
        wait_drain();
    endtask

    task automatic test_single_word(input logic [DW-1:0] d);
        int w;
        send_word(d, 1'b1, w);
        wait_drain();
    endtask

    task automatic test_reset_midflight();
        int w;
        for (int i = 0; i < NL; i++)
            send_word(32'h3F80_0000 + DW'(i), i == NL - 1, w);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fc_data !== '0 || fc_valid_pipeline !== '0 || res_valid !== 1'b0 || vec_count !== '0) begin
            n_fail++;
            $display("FAIL reset_midflight_outputs: vp=%b rv=%b cnt=%0d fc_data_nz=%b, want 0",
                     fc_valid_pipeline, res_valid, vec_count, |fc_data);
        end
        vec_q.delete();
        res_q.delete();
        fc_q.delete();
        midx = 0;
        mcnt = '0;
        rst  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (res_valid !== 1'b0 || s_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_midflight_quiet cyc %0d: rv=%b rdy=%b want 0/1", k, res_valid, s_ready);
            end
        end
        test_single_word(32'h4040_0000);
    endtask

    task automatic test_toggle_and_drain_ignore();
        int w;
        for (int i = 0; i < 2 * NL; i++) begin
            send_word(32'h4200_0000 ^ DW'(i * 3), i == 2 * NL - 1, w);
            @(negedge clk);
        end
        // Intake is closed while draining; these words must vanish.
        s_valid = 1'b1;
        s_last  = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        repeat (4) @(negedge clk);
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_ready: got %b want 0", s_ready);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        wait_drain();
        for (int i = 0; i < 3; i++)
            send_word(32'h3E00_0000 + DW'(i), i == 2, w);
        wait_drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_partial();
        test_single_word(32'h4080_0000);
        test_reset_midflight();
        test_toggle_and_drain_ignore();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
